// File: rtl/spi_reg_pkg.sv
// Shared types and frame-geometry helpers for the SPI register bank.
package spi_reg_pkg;

  // Frame decoder states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Total frame length: R/W flag, address field, data field.
  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Bit position of the R/W flag within the shift register (frame MSB).
  function automatic int unsigned rw_bit(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus delay flop; registered level and edge pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  // Synchronise din; level is the delay stage, edges compare it with s2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= RST_VAL;
      s2    <= RST_VAL;
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
      fall  <= ~s2 & level;
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-frame decoder into NUM_REGS control registers.
// Optional read-back on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned       NUM_REGS = 5,
  parameter int unsigned       ADDR_W   = 7,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       copi,
`ifdef SPI_READBACK_EN
  output logic                       cipo,
`endif
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int unsigned RW_BIT  = rw_bit(ADDR_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));

  wire unused_sync = ^{sclk_lvl, sclk_fall, cs_lvl, copi_rise, copi_fall};

  state_e             state, state_nxt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] shreg_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic               overrun;
  logic               start_c, shift_c, do_write_c, do_err_c;

  logic              frm_rw;
  logic [ADDR_W-1:0] frm_addr;
  logic [DATA_W-1:0] frm_data;
  logic              addr_ok;

  assign shreg_nxt = {shreg[FRAME_W-2:0], copi_lvl};
  assign frm_rw    = shreg[RW_BIT];
  assign frm_addr  = shreg[RW_BIT-1 -: ADDR_W];
  assign frm_data  = shreg[DATA_W-1:0];
  assign addr_ok   = 32'(frm_addr) < 32'(NUM_REGS);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and frame commit decisions.
  always_comb begin
    state_nxt  = state;
    start_c    = 1'b0;
    shift_c    = 1'b0;
    do_write_c = 1'b0;
    do_err_c   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          start_c   = 1'b1;
        end
      end
      SHIFT: begin
        shift_c = sclk_rise;
        if (cs_rise) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
        if (bit_cnt != CNT_W'(FRAME_W) || overrun) do_err_c   = 1'b1;
        else if (frm_rw && !addr_ok)               do_err_c   = 1'b1;
        else if (frm_rw)                           do_write_c = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and saturating bit counter; overrun marks a long frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else if (start_c) begin
      shreg   <= '0;
      bit_cnt <= '0;
      overrun <= 1'b0;
    end else if (shift_c) begin
      shreg <= shreg_nxt;
      if (bit_cnt != CNT_W'(FRAME_W)) bit_cnt <= bit_cnt + CNT_W'(1);
      else                            overrun <= 1'b1;
    end
  end

  // Register file update and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_flat <= {NUM_REGS{RST_VAL}};
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= do_write_c;
      frame_err <= do_err_c;
      if (do_write_c) begin
        wr_addr <= frm_addr;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (frm_addr == ADDR_W'(i)) regs_flat[i*DATA_W +: DATA_W] <= frm_data;
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] rd_word;
  logic              rd_frame;
  logic              hdr_done_c;
  logic              data_phase_c;

  assign hdr_done_c   = shift_c && (bit_cnt == CNT_W'(ADDR_W));
  assign data_phase_c = rd_frame && (bit_cnt >= CNT_W'(1 + ADDR_W)) && (bit_cnt < CNT_W'(FRAME_W));

  // Select the addressed register as the header completes; 0 if out of range.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (shreg_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_flat[i*DATA_W +: DATA_W];
    end
  end

  // Load the shadow on a read header, then shift it out MSB first on sclk falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      rd_frame <= 1'b0;
      cipo     <= 1'b0;
    end else if (start_c) begin
      shadow   <= '0;
      rd_frame <= 1'b0;
      cipo     <= 1'b0;
    end else begin
      if (hdr_done_c && !shreg_nxt[ADDR_W]) begin
        shadow   <= rd_word;
        rd_frame <= 1'b1;
      end
      if (state != SHIFT || cs_lvl) begin
        cipo <= 1'b0;
      end else if (sclk_fall) begin
        if (data_phase_c) {cipo, shadow} <= {shadow, 1'b0};
        else              cipo <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: writes, error frames, reset abort, read-back.
module tb_spi_reg_bank;

  localparam int unsigned NUM_REGS = 5;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       sclk;
  logic                       cs_n;
  logic                       copi;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;
`ifdef SPI_READBACK_EN
  logic                       cipo;
  logic [15:0]                rd_bits;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int n_err    = 0;
  int s0, e0;

  always #5 clk = ~clk;

  spi_reg_bank #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_VAL(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .copi(copi),
`ifdef SPI_READBACK_EN
    .cipo(cipo),
`endif
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  // Count output pulses away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) n_strobe++;
    if (frame_err === 1'b1) n_err++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive n bits of val MSB first; optionally release cs_n at the end.
  task automatic send(input logic [31:0] val, input int n, input bit release_cs);
`ifdef SPI_READBACK_EN
    rd_bits = '0;
`endif
    cs_n = 1'b0;
    wait_clk(6);
    for (int i = n - 1; i >= 0; i--) begin
      copi = val[i];
      wait_clk(6);
`ifdef SPI_READBACK_EN
      if (i < 16) rd_bits[i] = cipo;
`endif
      sclk = 1'b1;
      wait_clk(6);
      sclk = 1'b0;
    end
    wait_clk(6);
    if (release_cs) cs_n = 1'b1;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; copi = 1'b0;
    wait_clk(4);
    check("rst_regs", 64'(regs_flat), 64'h0);
    check("rst_strobe", 64'(wr_strobe), 64'h0);
    check("rst_addr", 64'(wr_addr), 64'h0);
    check("rst_err", 64'(frame_err), 64'h0);
    rst = 1'b0;
    wait_clk(4);

    // Write reg0 = A5 and check 5-cycle commit latency.
    s0 = n_strobe; e0 = n_err;
    send(32'h80A5, 16, 1'b1);
    repeat (4) @(posedge clk);
    #1 check("lat_before", 64'(regs_flat[7:0]), 64'h00);
    @(posedge clk);
    #1 check("lat_at", 64'(regs_flat[7:0]), 64'hA5);
    check("w0_strobe", 64'(wr_strobe), 64'h1);
    check("w0_addr", 64'(wr_addr), 64'h0);
    wait_clk(4);
    check("w0_regs", 64'(regs_flat), 64'h00_0000_00A5);
    check("w0_nstrobe", 64'(n_strobe - s0), 64'h1);
    check("w0_nerr", 64'(n_err - e0), 64'h0);

    // reg4 = 3C then reg1 = F0; both held.
    s0 = n_strobe; e0 = n_err;
    send(32'h843C, 16, 1'b1); wait_clk(8);
    check("w4_addr", 64'(wr_addr), 64'h4);
    send(32'h81F0, 16, 1'b1); wait_clk(8);
    check("w41_regs", 64'(regs_flat), 64'h3C_0000_F0A5);
    check("w41_addr", 64'(wr_addr), 64'h1);
    check("w41_nstrobe", 64'(n_strobe - s0), 64'h2);
    check("w41_nerr", 64'(n_err - e0), 64'h0);

    // Out-of-range write address.
    s0 = n_strobe; e0 = n_err;
    send(32'h85FF, 16, 1'b1); wait_clk(8);
    check("oor_regs", 64'(regs_flat), 64'h3C_0000_F0A5);
    check("oor_nerr", 64'(n_err - e0), 64'h1);
    check("oor_nstrobe", 64'(n_strobe - s0), 64'h0);
    check("oor_addr", 64'(wr_addr), 64'h1);

    // Short (10-bit) and long (17-bit) frames.
    s0 = n_strobe; e0 = n_err;
    send(32'h8011 >> 6, 10, 1'b1); wait_clk(8);
    check("short_nerr", 64'(n_err - e0), 64'h1);
    send(32'h1_0023, 17, 1'b1); wait_clk(8);
    check("long_nerr", 64'(n_err - e0), 64'h2);
    check("len_regs", 64'(regs_flat), 64'h3C_0000_F0A5);
    check("len_nstrobe", 64'(n_strobe - s0), 64'h0);

    // Read frame of reg3: no register change, no error.
    s0 = n_strobe; e0 = n_err;
    send(32'h0300, 16, 1'b1); wait_clk(8);
    check("rd_regs", 64'(regs_flat), 64'h3C_0000_F0A5);
    check("rd_nerr", 64'(n_err - e0), 64'h0);
    check("rd_nstrobe", 64'(n_strobe - s0), 64'h0);
`ifdef SPI_READBACK_EN
    check("rd_zero_cipo", 64'(rd_bits), 64'h0);
`endif

    // Reset after 6 bits of reg2 = 11 aborts frame and clears registers.
    send(32'h8211 >> 10, 6, 1'b0);
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; copi = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    check("abort_regs", 64'(regs_flat), 64'h0);
    check("abort_addr", 64'(wr_addr), 64'h0);
    s0 = n_strobe; e0 = n_err;
    send(32'h8222, 16, 1'b1); wait_clk(8);
    check("post_rst_regs", 64'(regs_flat), 64'h00_0022_0000);
    check("post_rst_addr", 64'(wr_addr), 64'h2);
    check("post_rst_nstrobe", 64'(n_strobe - s0), 64'h1);
    check("post_rst_nerr", 64'(n_err - e0), 64'h0);

`ifdef SPI_READBACK_EN
    // Write reg3 = 5A then read it back on cipo.
    send(32'h835A, 16, 1'b1); wait_clk(8);
    e0 = n_err;
    send(32'h0300, 16, 1'b1); wait_clk(8);
    check("rb_data", 64'(rd_bits[7:0]), 64'h5A);
    check("rb_hdr", 64'(rd_bits[15:8]), 64'h00);
    check("rb_nerr", 64'(n_err - e0), 64'h0);
    check("rb_regs", 64'(regs_flat), 64'h00_5A22_0000);
    check("rb_cipo_idle", 64'(cipo), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
